// File: rtl/btn_cond_pkg.sv
// Shared types for the push-button conditioner:
// per-channel state encoding and counter sizing.
package btn_cond_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEATING,
    DEB_RELEASE
  } btn_state_e;

  function automatic int cnt_width(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_if.sv
// Raw pins in, conditioned levels and strobes out.
// master = conditioner side, slave = consumer side.
interface btn_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] btn_raw;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_repeat;
  logic [N_CH-1:0] btn_act;

  modport master (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat,
    output btn_act
  );

  modport slave (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat,
    input  btn_act
  );
endinterface

// File: rtl/btn_channel.sv
// One button: 2-flop sync, debounce FSM, auto-repeat.
// All outputs registered.
module btn_channel
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_stb,
  output logic release_stb,
  output logic repeat_stb,
  output logic act_stb
);

  localparam int CW = cnt_width(
    DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DEB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST =
    CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST =
    CW'(REPEAT_PERIOD - 1);

  btn_state_e    state;
  logic          s1;
  logic          s2;
  logic          rep_mode;
  logic [CW-1:0] dcnt;
  logic [CW-1:0] rcnt;
  logic [CW-1:0] rcnt_inc;
  logic          pressed;
  logic          hit;

  assign pressed  = s2 ^ ACTIVE_LOW;
  assign rcnt_inc = (rcnt == '1) ? rcnt : rcnt + 1'b1;
  assign hit      = REPEAT_EN &&
    (rcnt == (rep_mode ? RP_LAST : RD_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= ACTIVE_LOW;
      s2          <= ACTIVE_LOW;
      state       <= IDLE;
      rep_mode    <= 1'b0;
      dcnt        <= '0;
      rcnt        <= '0;
      level       <= 1'b0;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
      repeat_stb  <= 1'b0;
      act_stb     <= 1'b0;
    end else begin
      s1          <= raw;
      s2          <= s1;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
      repeat_stb  <= 1'b0;
      act_stb     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pressed) begin
            state <= DEB_PRESS;
            dcnt  <= CW'(1);
          end
        end
        DEB_PRESS: begin
          if (!pressed) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (dcnt == DEB_LAST) begin
            state     <= HELD;
            level     <= 1'b1;
            press_stb <= 1'b1;
            act_stb   <= 1'b1;
            rep_mode  <= 1'b0;
            rcnt      <= '0;
            dcnt      <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        HELD, REPEATING, DEB_RELEASE: begin
          // a bounce back to pressed resumes the held
          // state and its repeat timing in the same edge
          if (pressed) begin
            dcnt <= '0;
            if (hit) begin
              state      <= REPEATING;
              rep_mode   <= 1'b1;
              repeat_stb <= 1'b1;
              act_stb    <= 1'b1;
              rcnt       <= '0;
            end else begin
              state <= rep_mode ? REPEATING : HELD;
              rcnt  <= rcnt_inc;
            end
          end else if (state != DEB_RELEASE) begin
            state <= DEB_RELEASE;
            dcnt  <= CW'(1);
          end else if (dcnt == DEB_LAST) begin
            state       <= IDLE;
            level       <= 1'b0;
            release_stb <= 1'b1;
            dcnt        <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// N-channel push-button front end: one independent
// btn_channel per pin, outputs concatenated.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned     N_CH            = 4,
  parameter int unsigned     DEBOUNCE_CYCLES = 50000,
  parameter int unsigned     REPEAT_DELAY    = 50000000,
  parameter int unsigned     REPEAT_PERIOD   = 10000000,
  parameter logic [N_CH-1:0] REPEAT_EN  = {N_CH{1'b1}},
  parameter logic [N_CH-1:0] ACTIVE_LOW = {N_CH{1'b0}}
) (
  input logic   clk_100mhz,
  input logic   rst_btn,
  btn_if.master btns
);

  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] rls;
  logic [N_CH-1:0] rpt;
  logic [N_CH-1:0] act;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_EN[i]),
      .ACTIVE_LOW      (ACTIVE_LOW[i])
    ) u_ch (
      .clk         (clk_100mhz),
      .rst         (rst_btn),
      .raw         (btns.btn_raw[i]),
      .level       (level[i]),
      .press_stb   (press[i]),
      .release_stb (rls[i]),
      .repeat_stb  (rpt[i]),
      .act_stb     (act[i])
    );
  end

  assign btns.btn_level   = level;
  assign btns.btn_press   = press;
  assign btns.btn_release = rls;
  assign btns.btn_repeat  = rpt;
  assign btns.btn_act     = act;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: event-rule reference model
// feeding a per-cycle scoreboard, plus directed timing checks.
module tb_btn_conditioner;

  localparam int NCH  = 4;
  localparam int DEB  = 8;
  localparam int RDLY = 20;
  localparam int RPER = 5;
  localparam logic [3:0] EN = 4'b0111;
  localparam logic [3:0] AL = 4'b1000;

  typedef int iq_t[$];
  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
    logic [3:0] act;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  btn_if #(.N_CH(NCH)) bus ();

  btn_conditioner #(
    .N_CH            (NCH),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER),
    .REPEAT_EN       (EN),
    .ACTIVE_LOW      (AL)
  ) dut (
    .clk_100mhz (clk),
    .rst_btn    (rst),
    .btns       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  obs_t expq[$];
  iq_t  press_q[NCH];
  iq_t  rpt_q[NCH];
  iq_t  rel_q[NCH];
  iq_t  act_q[NCH];

  // reference model: pin seen two edges late, then
  // run-length rules on the pressed/not-pressed stream
  bit [3:0] m_s1 = AL;
  bit [3:0] m_s2 = AL;
  bit [3:0] m_lvl = '0;
  int run[NCH];
  int rrun[NCH];
  int age[NCH];
  int nrep[NCH];

  task automatic model_step();
    obs_t e;
    bit   p;
    e = '0;
    if (rst) begin
      m_s1 = AL;
      m_s2 = AL;
      m_lvl = '0;
      for (int i = 0; i < NCH; i++) begin
        run[i] = 0; rrun[i] = 0;
        age[i] = 0; nrep[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        p = m_s2[i] ^ AL[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = bus.btn_raw[i];
        if (!m_lvl[i]) begin
          run[i] = p ? run[i] + 1 : 0;
          if (run[i] == DEB) begin
            m_lvl[i] = 1'b1;
            e.prs[i] = 1'b1;
            run[i] = 0; rrun[i] = 0;
            age[i] = 0; nrep[i] = 0;
          end
        end else if (!p) begin
          rrun[i]++;
          if (rrun[i] == DEB) begin
            m_lvl[i] = 1'b0;
            e.rel[i] = 1'b1;
            rrun[i] = 0;
          end
        end else begin
          rrun[i] = 0;
          age[i]++;
          if (EN[i] &&
              age[i] == (nrep[i] == 0 ? RDLY : RPER)) begin
            e.rpt[i] = 1'b1;
            age[i] = 0;
            nrep[i]++;
          end
        end
      end
    end
    e.lvl = m_lvl;
    e.act = e.prs | e.rpt;
    expq.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // monitor: one expected observation per clock
  initial forever begin
    obs_t e;
    obs_t got;
    @(negedge clk);
    got = {bus.btn_level, bus.btn_press, bus.btn_release,
           bus.btn_repeat, bus.btn_act};
    n_tests++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty cyc=%0d got=%h",
               cyc, got);
    end else begin
      e = expq.pop_front();
      if (got !== e) begin
        n_fail++;
        $display({"FAIL cycle_obs cyc=%0d lvl/prs/rel/rpt/act",
                  " got %h/%h/%h/%h/%h exp %h/%h/%h/%h/%h"},
                 cyc, got.lvl, got.prs, got.rel, got.rpt,
                 got.act, e.lvl, e.prs, e.rel, e.rpt, e.act);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (bus.btn_press[i] === 1'b1) press_q[i].push_back(cyc);
      if (bus.btn_repeat[i] === 1'b1) rpt_q[i].push_back(cyc);
      if (bus.btn_release[i] === 1'b1) rel_q[i].push_back(cyc);
      if (bus.btn_act[i] === 1'b1) act_q[i].push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d exceeded time limit", cyc);
    $fatal(1, "watchdog");
  end

  function automatic iq_t since(iq_t q, int t0);
    iq_t r;
    foreach (q[k]) if (q[k] > t0) r.push_back(q[k] - t0);
    return r;
  endfunction

  function automatic string fmt(iq_t q);
    string s;
    s = "{";
    foreach (q[k]) s = {s, $sformatf(" %0d", q[k])};
    return {s, " }"};
  endfunction

  task automatic check(string name, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_list(string name, iq_t got, iq_t exp);
    bit ok;
    ok = (got.size() == exp.size());
    if (ok) foreach (exp[k]) if (got[k] != exp[k]) ok = 0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s",
               name, fmt(got), fmt(exp));
    end
  endtask

  task automatic ticks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(string name);
    check(name, int'({bus.btn_level, bus.btn_press,
          bus.btn_release, bus.btn_repeat, bus.btn_act}), 0);
  endtask

  initial begin
    int   t0;
    int   hold[NCH];
    iq_t  e;
    bus.btn_raw = 4'b1111;
    rst = 1'b1;
    ticks(3);
    check_all_zero("reset_outputs");
    check("reset_ch3_level", int'(bus.btn_level[3]), 0);
    rst = 1'b0;
    bus.btn_raw = AL;
    ticks(15);
    check("idle_ch3_level", int'(bus.btn_level[3]), 0);

    // glitch on ch0
    t0 = cyc;
    bus.btn_raw[0] = 1'b1;
    ticks(5);
    bus.btn_raw[0] = 1'b0;
    ticks(25);
    e = {};
    check_list("glitch_press", since(press_q[0], t0), e);
    check("glitch_level", int'(bus.btn_level[0]), 0);

    // clean press ch0
    t0 = cyc;
    bus.btn_raw[0] = 1'b1;
    ticks(60);
    bus.btn_raw[0] = 1'b0;
    ticks(25);
    e = '{10};
    check_list("clean_press", since(press_q[0], t0), e);
    e = '{30, 35, 40, 45, 50, 55, 60};
    check_list("clean_repeat", since(rpt_q[0], t0), e);
    e = '{70};
    check_list("clean_release", since(rel_q[0], t0), e);
    e = '{10, 30, 35, 40, 45, 50, 55, 60};
    check_list("clean_act", since(act_q[0], t0), e);

    // release bounce on ch1
    t0 = cyc;
    bus.btn_raw[1] = 1'b1;
    ticks(37);
    bus.btn_raw[1] = 1'b0;
    ticks(4);
    bus.btn_raw[1] = 1'b1;
    ticks(19);
    bus.btn_raw[1] = 1'b0;
    ticks(25);
    e = '{30, 35, 44, 49, 54, 59};
    check_list("bounce_repeat", since(rpt_q[1], t0), e);
    e = '{70};
    check_list("bounce_release", since(rel_q[1], t0), e);

    // ch3 (no repeat, active-low) with ch0 concurrently
    t0 = cyc;
    bus.btn_raw[3] = 1'b0;
    bus.btn_raw[0] = 1'b1;
    ticks(50);
    bus.btn_raw[3] = 1'b1;
    bus.btn_raw[0] = 1'b0;
    ticks(25);
    e = '{10};
    check_list("conc_press_ch3", since(press_q[3], t0), e);
    check_list("conc_press_ch0", since(press_q[0], t0), e);
    e = {};
    check_list("conc_repeat_ch3", since(rpt_q[3], t0), e);
    e = '{60};
    check_list("conc_release_ch3", since(rel_q[3], t0), e);
    e = '{30, 35, 40, 45, 50};
    check_list("conc_repeat_ch0", since(rpt_q[0], t0), e);

    // reset while ch2 is repeating
    t0 = cyc;
    bus.btn_raw[2] = 1'b1;
    ticks(33);
    rst = 1'b1;
    ticks(1);
    check_all_zero("midreset_outputs");
    rst = 1'b0;
    ticks(16);
    bus.btn_raw[2] = 1'b0;
    ticks(25);
    e = '{10, 44};
    check_list("midreset_press", since(press_q[2], t0), e);
    e = '{30};
    check_list("midreset_repeat", since(rpt_q[2], t0), e);
    e = '{60};
    check_list("midreset_release", since(rel_q[2], t0), e);

    // randomized pin activity with occasional resets
    for (int i = 0; i < NCH; i++) hold[i] = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NCH; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          bus.btn_raw[i] = ~bus.btn_raw[i];
          hold[i] = ($urandom_range(0, 3) == 0) ?
            int'($urandom_range(1, 6)) :
            int'($urandom_range(7, 45));
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      ticks(1);
    end
    rst = 1'b0;
    bus.btn_raw = AL;
    ticks(30);
    check("final_level", int'(bus.btn_level), 0);
    check("scoreboard_drained", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
